seg7_capture: RTL

- Observes an external 7-segment bus, such as a neighbouring tile's display outputs wired to ui_in, and recovers the hex digit being shown.
- Filters glitches with a stability counter and decodes the segment pattern back to 4 bits.
- Checks that successive digits follow the up-counting sequence 0..F, wrapping F to 0.
- Acts as the readback/checker counterpart of the team's hex counter-to-7-seg display path.

---
 rtl/seg7_capture_pkg.sv | 18 +
 rtl/seg7_capture_if.sv | 21 ++
 rtl/seg7_decode.sv | 24 ++
 rtl/seg7_capture.sv | 135 +++++++++++++
 4 files changed

// File: rtl/seg7_capture_pkg.sv
// Shared definitions for the 7-segment readback path: glyph table, blank code, FSM states.
package seg7_capture_pkg;

  // Segment order gfedcba, lit = 1.
  localparam logic [6:0] GLYPH [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Segment bus in, recovered digit and status out.
interface seg7_capture_if;
  logic [6:0] seg_in;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       digit_strobe;
  logic       blank;
  logic       invalid;
  logic       seq_err;
  logic [7:0] err_count;

  modport master (
    output seg_in,
    input  digit_out, digit_valid, digit_strobe, blank, invalid, seq_err, err_count
  );

  modport slave (
    input  seg_in,
    output digit_out, digit_valid, digit_strobe, blank, invalid, seq_err, err_count
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to hex digit decoder; flags blank and non-glyph patterns.
module seg7_decode
  import seg7_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       is_hex,
  output logic       is_blank,
  output logic [3:0] digit
);

  always_comb begin
    is_hex = 1'b0;
    digit  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH[i]) begin
        is_hex = 1'b1;
        digit  = 4'(i);
      end
    end
  end

  assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_capture.sv
// Recovers the hex digit shown on a 7-segment bus and checks it counts up 0..F.
// SEG7_CAPTURE_ACTIVE_LOW_EN: accept a common-anode (lit = 0) bus.
//
// state  | meaning
// IDLE   | no pattern change seen since reset
// SETTLE | candidate pattern being timed for stability
// LOCKED | candidate accepted, outputs reflect it
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_capture_if.slave     bus
);

  logic [6:0] sync1, sync2, seg_s;

`ifdef SEG7_CAPTURE_ACTIVE_LOW_EN
  // Flops hold the raw bus; resetting them to all-ones makes a dark bus read as blank.
  localparam logic [6:0] SYNC_RST = 7'h7F;
  assign seg_s = ~sync2;
`else
  localparam logic [6:0] SYNC_RST = 7'h00;
  assign seg_s = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= SYNC_RST;
      sync2 <= SYNC_RST;
    end else begin
      sync1 <= bus.seg_in;
      sync2 <= sync1;
    end
  end

  state_t           state, state_nxt;
  logic [6:0]       cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, change;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= SEG_BLANK;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    change    = 1'b0;
    if (seg_s != cand) begin
      change    = 1'b1;
      cand_nxt  = seg_s;
      cnt_nxt   = '0;
      state_nxt = SETTLE;
    end else if (state == SETTLE) begin
      if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
        accept    = 1'b1;
        state_nxt = LOCKED;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  logic       is_hex, is_blank;
  logic [3:0] digit;

  seg7_decode u_decode (
    .pattern  (cand),
    .is_hex   (is_hex),
    .is_blank (is_blank),
    .digit    (digit)
  );

  logic [3:0] digit_q;
  logic       valid_q, strobe_q, blank_q, invalid_q, seq_err_q, have_prev;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q   <= 4'd0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      blank_q   <= 1'b0;
      invalid_q <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
      have_prev <= 1'b0;
    end else begin
      strobe_q  <= 1'b0;
      seq_err_q <= 1'b0;
      if (change) begin
        valid_q   <= 1'b0;
        blank_q   <= 1'b0;
        invalid_q <= 1'b0;
      end else if (accept) begin
        valid_q   <= is_hex;
        blank_q   <= is_blank;
        invalid_q <= !is_hex && !is_blank;
        // Re-accepting the digit already shown is glitch recovery, not a new count.
        if (is_hex && (!have_prev || digit != digit_q)) begin
          digit_q   <= digit;
          strobe_q  <= 1'b1;
          have_prev <= 1'b1;
          if (have_prev && digit != digit_q + 4'd1) begin
            seq_err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
      end
    end
  end

  assign bus.digit_out    = digit_q;
  assign bus.digit_valid  = valid_q;
  assign bus.digit_strobe = strobe_q;
  assign bus.blank        = blank_q;
  assign bus.invalid      = invalid_q;
  assign bus.seq_err      = seq_err_q;
  assign bus.err_count    = err_cnt_q;

endmodule
